// File: rtl/redir_if.sv
// Redirect handshake between branch resolution and fetch.
// master drives the target; slave (fetch) returns ready.
interface redir_if #(
  parameter int PC_W   = 32,
  parameter int SLOT_W = 1
);
  logic              redir_valid;
  logic [PC_W-1:0]   redir_pc;
  logic [SLOT_W-1:0] redir_slot;
  logic              redir_ready;

  modport master (
    output redir_valid,
    output redir_pc,
    output redir_slot,
    input  redir_ready
  );

  modport slave (
    input  redir_valid,
    input  redir_pc,
    input  redir_slot,
    output redir_ready
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Oldest-taken-branch redirect sequencer: IDLE -> REDIRECT -> FLUSH.
// Optional counters: define BR_REDIRECT_STATS_EN.
module branch_redirect_ctrl #(
  parameter int NUM_SLOTS    = 2,
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SLOTS-1:0]      br_valid,
  input  logic [NUM_SLOTS-1:0]      br_taken,
  input  logic [NUM_SLOTS*PC_W-1:0] br_target,
  redir_if.master                   redir,
`ifdef BR_REDIRECT_STATS_EN
  output logic [31:0]               stat_taken,
  output logic [31:0]               stat_not_taken,
  output logic [31:0]               stat_redirects,
`endif
  output logic                      flush_o,
  output logic                      stall_o
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REDIRECT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic                 valid_q;
  logic [PC_W-1:0]      pc_q;
  logic [SLOT_W-1:0]    slot_q;
  logic                 flush_q;

  logic [NUM_SLOTS-1:0] qual;
  logic                 win_found;
  logic [SLOT_W-1:0]    win_idx;
  logic [PC_W-1:0]      win_pc;
  logic                 hs;

  assign qual = br_valid & br_taken;
  assign hs   = valid_q & redir.redir_ready;

  // Scan downward so the lowest qualifying slot is the last write.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_pc    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (qual[i]) begin
        win_found = 1'b1;
        win_idx   = SLOT_W'(i);
        win_pc    = br_target[i*PC_W +: PC_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      slot_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state   <= REDIRECT;
            valid_q <= 1'b1;
            pc_q    <= win_pc;
            slot_q  <= win_idx;
          end
        end
        REDIRECT: begin
          if (hs) begin
            state   <= FLUSH;
            valid_q <= 1'b0;
            flush_q <= 1'b1;
            cnt     <= CNT_W'(FLUSH_CYCLES);
          end
        end
        FLUSH: begin
          if (cnt == CNT_W'(1)) begin
            state   <= IDLE;
            flush_q <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          flush_q <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

  assign redir.redir_valid = valid_q;
  assign redir.redir_pc    = pc_q;
  assign redir.redir_slot  = slot_q;
  assign flush_o           = flush_q;
  assign stall_o           = (state != IDLE);

`ifdef BR_REDIRECT_STATS_EN
  logic [31:0] n_tk;
  logic [31:0] n_nt;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_comb begin
    n_tk = '0;
    n_nt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (br_valid[i] && br_taken[i])  n_tk = n_tk + 32'd1;
      if (br_valid[i] && !br_taken[i]) n_nt = n_nt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
      stat_redirects <= '0;
    end else begin
      if (state == IDLE) begin
        stat_taken     <= sat_add(stat_taken, n_tk);
        stat_not_taken <= sat_add(stat_not_taken, n_nt);
      end
      if (state == REDIRECT && hs)
        stat_redirects <= sat_add(stat_redirects, 32'd1);
    end
  end
`endif

`ifndef SYNTHESIS
  // Fetch tolerates it, but a misaligned target usually means a bad decode.
  always @(posedge clk) begin
    if (rst_n && state == IDLE && win_found && win_pc[1:0] != 2'b00)
      $error("misaligned redirect target %h", win_pc);
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl.
// Redirect targets are queued on issue and matched at handshake.
module tb_branch_redirect_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [0:0]  slot;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  br_valid;
  logic [1:0]  br_taken;
  logic [63:0] br_target;
  logic        flush_o;
  logic        stall_o;
`ifdef BR_REDIRECT_STATS_EN
  logic [31:0] stat_taken;
  logic [31:0] stat_not_taken;
  logic [31:0] stat_redirects;
`endif

  int   n_chk  = 0;
  int   n_pass = 0;
  int   nf;
  int   ns;
  exp_t sb[$];

  redir_if #(.PC_W(32), .SLOT_W(1)) rif ();

  branch_redirect_ctrl #(
    .NUM_SLOTS(2),
    .PC_W(32),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .br_valid(br_valid),
    .br_taken(br_taken),
    .br_target(br_target),
    .redir(rif),
`ifdef BR_REDIRECT_STATS_EN
    .stat_taken(stat_taken),
    .stat_not_taken(stat_not_taken),
    .stat_redirects(stat_redirects),
`endif
    .flush_o(flush_o),
    .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input logic [1:0]  v,
    input logic [1:0]  t,
    input logic [31:0] t0,
    input logic [31:0] t1
  );
    br_valid  = v;
    br_taken  = t;
    br_target = {t1, t0};
    tick();
    br_valid = 2'b00;
    br_taken = 2'b00;
  endtask

  task automatic count(input int n);
    nf = 0;
    ns = 0;
    for (int i = 0; i < n; i++) begin
      if (flush_o) nf++;
      if (stall_o) ns++;
      tick();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rif.redir_valid && rif.redir_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $error("FAIL sb_unexpected: got pc %h want none", rif.redir_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc", rif.redir_pc, e.pc);
        check("sb_slot", 32'(rif.redir_slot), 32'(e.slot));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    br_valid = 2'b00;
    br_taken = 2'b00;
    br_target = '0;
    rif.redir_ready = 1'b0;
    #22;
    check("rst_valid", 32'(rif.redir_valid), 0);
    check("rst_pc", rif.redir_pc, 0);
    check("rst_slot", 32'(rif.redir_slot), 0);
    check("rst_flush", 32'(flush_o), 0);
    check("rst_stall", 32'(stall_o), 0);
    rst_n = 1'b1;
    tick();

    // basic slot-0 redirect
    rif.redir_ready = 1'b1;
    sb.push_back('{pc: 32'h1000, slot: 1'b0});
    issue(2'b01, 2'b01, 32'h1000, 32'h0);
    check("t1_valid", 32'(rif.redir_valid), 1);
    check("t1_pc", rif.redir_pc, 32'h1000);
    count(5);
    check("t1_flush_cycles", nf, 2);
    check("t1_stall_cycles", ns, 3);
    check("t1_idle", 32'(stall_o), 0);

    // both taken: lowest wins; taken at FLUSH exit ignored
    sb.push_back('{pc: 32'h200, slot: 1'b0});
    issue(2'b11, 2'b11, 32'h200, 32'h300);
    check("t2_pc", rif.redir_pc, 32'h200);
    check("t2_slot", 32'(rif.redir_slot), 0);
    tick();
    check("t2_flush1", 32'(flush_o), 1);
    tick();
    check("t2_flush2", 32'(flush_o), 1);
    issue(2'b01, 2'b01, 32'hA00, 32'h0);
    check("t2_exit_stall", 32'(stall_o), 0);
    tick();
    check("t2_exit_ignored", 32'(rif.redir_valid), 0);

    // slot 0 not taken, slot 1 taken
    sb.push_back('{pc: 32'h500, slot: 1'b1});
    issue(2'b11, 2'b10, 32'h400, 32'h500);
    check("t3_pc", rif.redir_pc, 32'h500);
    check("t3_slot", 32'(rif.redir_slot), 1);
    count(4);
    check("t3_flush_cycles", nf, 2);

    // backpressure from fetch
    rif.redir_ready = 1'b0;
    sb.push_back('{pc: 32'h600, slot: 1'b0});
    issue(2'b01, 2'b01, 32'h600, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(rif.redir_valid), 1);
      check("t4_hold_pc", rif.redir_pc, 32'h600);
      check("t4_no_flush", 32'(flush_o), 0);
      tick();
    end
    rif.redir_ready = 1'b1;
    tick();
    check("t4_flush_start", 32'(flush_o), 1);
    check("t4_valid_drop", 32'(rif.redir_valid), 0);
    tick();
    check("t4_flush_second", 32'(flush_o), 1);
    tick();
    check("t4_idle", 32'(stall_o), 0);

    // not-taken and invalid-taken bits do nothing
    br_target = {32'h700, 32'h704};
    for (int i = 0; i < 10; i++) begin
      br_valid = 2'b01;
      br_taken = (i % 2 == 0) ? 2'b00 : 2'b10;
      tick();
      check("t5_valid", 32'(rif.redir_valid), 0);
      check("t5_stall", 32'(stall_o), 0);
      check("t5_flush", 32'(flush_o), 0);
    end
    br_valid = 2'b00;
    br_taken = 2'b00;

    // async reset mid-FLUSH with counter at 1
    sb.push_back('{pc: 32'h708, slot: 1'b0});
    issue(2'b01, 2'b01, 32'h708, 32'h0);
    tick();
    tick();
    check("t6_flush_pre", 32'(flush_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_flush_rst", 32'(flush_o), 0);
    check("t6_stall_rst", 32'(stall_o), 0);
    check("t6_pc_rst", rif.redir_pc, 0);
    rst_n = 1'b1;
    tick();

    // async reset mid-REDIRECT drops the request
    rif.redir_ready = 1'b0;
    issue(2'b10, 2'b10, 32'h0, 32'h800);
    check("t7_valid_pre", 32'(rif.redir_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_valid_rst", 32'(rif.redir_valid), 0);
    check("t7_slot_rst", 32'(rif.redir_slot), 0);
    check("t7_stall_rst", 32'(stall_o), 0);
    rst_n = 1'b1;
    rif.redir_ready = 1'b1;
    tick();
    check("t7_dropped", 32'(rif.redir_valid), 0);

    // normal redirect after reset
    sb.push_back('{pc: 32'h904, slot: 1'b1});
    issue(2'b10, 2'b10, 32'h0, 32'h904);
    check("t8_pc", rif.redir_pc, 32'h904);
    check("t8_slot", 32'(rif.redir_slot), 1);
    count(4);
    check("t8_flush_cycles", nf, 2);
    check("t8_stall_cycles", ns, 3);

`ifdef BR_REDIRECT_STATS_EN
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{pc: 32'hB00 + 32'(i*4), slot: 1'b0});
      issue(2'b01, 2'b01, 32'hB00 + 32'(i*4), 32'h0);
      tick();
      tick();
      tick();
    end
    issue(2'b01, 2'b00, 32'h0, 32'h0);
    issue(2'b01, 2'b00, 32'h0, 32'h0);
    check("st_taken", stat_taken, 3);
    check("st_not_taken", stat_not_taken, 2);
    check("st_redirects", stat_redirects, 3);
`endif

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
